// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: op encodings, FSM state codes and op-decode helpers for the mul/div sequencer
package muldiv_seq_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;
  function automatic logic is_div(md_op_e op);
    return op[1];
  endfunction
  function automatic logic is_signed(md_op_e op);
    return ~op[0];
  endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX/ID-side request, MT write, HI/LO read and stall signals of the sequencer
interface muldiv_seq_if import muldiv_seq_pkg::*; #(parameter int WIDTH = 32);
  logic             start, mthi, mtlo, hilo_rd, abort, busy, stall;
  md_op_e           op;
  logic [WIDTH-1:0] srca, srcb, wd, hi, lo;
  modport master (output start, op, srca, srcb, mthi, mtlo, wd, hilo_rd, abort,
                  input  hi, lo, busy, stall);
  modport slave  (input  start, op, srca, srcb, mthi, mtlo, wd, hilo_rd, abort,
                  output hi, lo, busy, stall);
endinterface

// File: rtl/muldiv_seq_step.sv
// md_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration
module md_step #(parameter int WIDTH = 32) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0]   w_sum, w_rem;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  // mul: add multiplicand on the multiplier LSB, then shift {acc,mplr} right; div: shift in and trial-subtract
  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_rem  = {i_hi, i_lo[WIDTH-1]};
    w_ge   = w_rem >= {1'b0, i_b};
    w_diff = w_rem[WIDTH-1:0] - i_b;
    o_hi   = i_div ? (w_ge ? w_diff : w_rem[WIDTH-1:0]) : w_sum[WIDTH:1];
    o_lo   = i_div ? {i_lo[WIDTH-2:0], w_ge} : {w_sum[0], i_lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with hazard stall
module muldiv_seq import muldiv_seq_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic      clk,
  input  logic      reset,
  muldiv_seq_if.slave io
);
  md_state_e        r_state, w_next;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_b, r_hi, r_lo;
  logic             r_div, r_neg_res, r_neg_rem;
  logic             w_sa, w_sb, w_dz, w_busy;
  logic [WIDTH-1:0] w_ma, w_mb, w_step_hi, w_step_lo, w_fix_hi, w_fix_lo;
  logic [2*WIDTH-1:0] w_neg_prod;

  // operands are reduced to magnitudes; signs are reapplied in FIX
  assign w_sa       = is_signed(io.op) & io.srca[WIDTH-1];
  assign w_sb       = is_signed(io.op) & io.srcb[WIDTH-1];
  assign w_ma       = w_sa ? -io.srca : io.srca;
  assign w_mb       = w_sb ? -io.srcb : io.srcb;
  assign w_dz       = is_div(io.op) & (io.srcb == '0);
  assign w_neg_prod = -{r_acc, r_q};
  assign w_fix_hi   = r_div ? (r_neg_rem ? -r_acc : r_acc) : (r_neg_res ? w_neg_prod[2*WIDTH-1:WIDTH] : r_acc);
  assign w_fix_lo   = r_div ? (r_neg_res ? -r_q : r_q) : (r_neg_res ? w_neg_prod[WIDTH-1:0] : r_q);
  assign w_busy     = r_state != S_IDLE;
  assign io.busy    = w_busy;
  assign io.stall   = w_busy & (io.hilo_rd | io.start);
  assign io.hi      = r_hi;
  assign io.lo      = r_lo;

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_div),
    .i_hi  (r_acc),
    .i_lo  (r_q),
    .i_b   (r_b),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;

  // next state: abort cancels any busy state; divide by zero skips the iterations
  always_comb begin
    w_next = (io.abort && w_busy) ? S_IDLE :
             (r_state == S_IDLE)  ? (io.start ? (w_dz ? S_FIX : S_RUN) : S_IDLE) :
             (r_state == S_RUN)   ? ((r_cnt == '0) ? S_FIX : S_RUN) : S_IDLE;
  end

  // operand latch, iteration, counter and HI/LO updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_div     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (io.start) begin
        r_div     <= is_div(io.op);
        r_cnt     <= CNTW'(WIDTH-1);
        r_b       <= is_div(io.op) ? w_mb : w_ma;
        r_acc     <= w_dz ? io.srca : '0;
        r_q       <= w_dz ? '1 : (is_div(io.op) ? w_ma : w_mb);
        r_neg_res <= ~w_dz & (w_sa ^ w_sb);
        r_neg_rem <= ~w_dz & w_sa;
      end else begin
        if (io.mthi) r_hi <= io.wd;
        if (io.mtlo) r_lo <= io.wd;
      end
    end else if (r_state == S_RUN) begin
      r_acc <= w_step_hi;
      r_q   <= w_step_lo;
      if (r_cnt != '0) r_cnt <= r_cnt - CNTW'(1);
    end else if (r_state == S_FIX && !io.abort) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end
  end
endmodule
